serial_subtractor32: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/serial_subtractor32_sub_digit.sv | 19 +
 rtl/serial_subtractor32.sv | 130 +++++++++++++
 tb/tb_serial_subtractor32.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;

  localparam logic OUT_FLAG_RST = 1'b0;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // One extra count value marks the settle cycle before DONE.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor32_sub_digit.sv
// Combinational DIGIT-bit subtract slice: {bo, d} = x - y - bi.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] res;

  // Top bit of the widened difference is set exactly when the result is negative.
  assign res = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d   = res[DIGIT-1:0];
  assign bo  = res[DIGIT];

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial WIDTH-bit subtractor, diff = a - b - bin, DIGIT bits per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
import serial_sub_pkg::*;

module serial_subtractor32 #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int CNT_W = cnt_width(N);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_subtractor32: DIGIT must divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT-1:0]   dig_d;
  logic               dig_bo;
  logic               last_run;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .bi (borrow_q),
    .d  (dig_d),
    .bo (dig_bo)
  );

  // Ready is withheld while reset is asserted even though the state is already IDLE.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = borrow_q;
  assign last_run  = (state_q == S_RUN) && (cnt_q == CNT_W'(N));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(N)) begin
          state_d = S_DONE;
        end else begin
          a_d      = a_q >> DIGIT;
          b_d      = b_q >> DIGIT;
          diff_d   = {dig_d, diff_q[WIDTH-1:DIGIT]};
          borrow_d = dig_bo;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= OUT_FLAG_RST;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_s_q, b_s_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s_q <= 1'b0;
      b_s_q <= 1'b0;
      ovf_q <= OUT_FLAG_RST;
    end else begin
      if (in_valid && in_ready) begin
        a_s_q <= a[WIDTH-1];
        b_s_q <= b[WIDTH-1];
      end
      if (last_run) ovf_q <= (a_s_q != b_s_q) && (diff_q[WIDTH-1] != a_s_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor32.sv
// Self-checking bench for serial_subtractor32: directed literals plus a random soak
// checked against an arithmetic reference model on every valid output cycle.
module tb_serial_subtractor32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_subtractor32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf     (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_results = 0;
  res_t exp_q[$];

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t   r;
    longint sd;
    longint ux, uy;
    ux     = longint'(x);
    uy     = longint'(y);
    r.diff = W'(ux - uy - longint'(bi));
    r.bout = (ux < uy + longint'(bi));
    sd     = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
    r.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_valid_without_op: out_valid 1 with no outstanding op, expected 0");
      end else begin
        check("soak_diff", diff, exp_q[0].diff);
        check("soak_bout", bout, exp_q[0].bout);
`ifdef SERIAL_SUB_OVF_EN
        check("soak_ovf", ovf, exp_q[0].ovf);
`endif
        check("ready_in_done", in_ready, 0);
        if (out_ready && !rst) begin
          void'(exp_q.pop_front());
          n_results++;
        end
      end
    end
    if (rst) exp_q.delete();
    if (!rst && in_valid && in_ready) exp_q.push_back(model(a, b, bin));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int t;
    t = 0;
    a = x;
    b = y;
    bin = bi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready 0 after 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    bin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic bi, input logic [W-1:0] ed, input logic eb,
                              input logic eo);
    res_t r;
    int   cyc;
    r = model(x, y, bi);
    check({nm, "_model_diff"}, r.diff, ed);
    check({nm, "_model_bout"}, r.bout, eb);
    check({nm, "_model_ovf"}, r.ovf, eo);
    out_ready = 1'b0;
    start_op(x, y, bi);
    wait_valid(cyc);
    check({nm, "_latency"}, cyc, 9);
    check({nm, "_diff"}, diff, ed);
    check({nm, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({nm, "_ovf"}, ovf, eo);
`endif
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   base;
    int   t;
    bit   soak_done;
    logic [W-1:0] x, y;

    tick(3);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick(1);
    check("post_rst_in_ready", in_ready, 1);

    run_directed("basic",     32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h55555555, 1'b0, 1'b1);
    run_directed("zero_bin",  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_directed("one_two",   32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_directed("ovf_neg",   32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_directed("five_three", 32'd5,       32'd3,        1'b0, 32'd2,        1'b0, 1'b0);
    run_directed("all_ones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_directed("ovf_pos",   32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);

    // Backpressure: result held while new operands are offered and refused.
    out_ready = 1'b0;
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      tick(1);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff", diff, 32'h77777787);
      check("bp_bout", bout, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // Reset during the third RUN cycle.
    start_op(32'd100, 32'd1, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick(1);
    check("midrst_release_in_ready", in_ready, 1);
    run_directed("after_rst", 32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0);

    // Random soak with random consumer stalls.
    base = n_results;
    soak_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          case ($urandom_range(0, 4))
            0: begin x = $urandom; y = x; end
            1: begin x = '0; y = $urandom; end
            2: begin x = $urandom; y = '1; end
            default: begin x = $urandom; y = $urandom; end
          endcase
          start_op(x, y, 1'($urandom_range(0, 1)));
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    check("soak_result_count", n_results - base, 200);
    check("soak_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
